lfsr_seq_ctrl: RTL

LFSR_SEQ_CTRL -- requirements
Module: lfsr_seq_ctrl

---
 rtl/lfsr_seq_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/lfsr_seq_ctrl.sv
// Sequencing controller for an external LFSR: seeds it, then either measures its
// period (mode 0) or runs it a fixed number of steps (mode 1) and reports the result.
module lfsr_seq_ctrl #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         mode,
    input  logic [N-1:0] seed_in,
    input  logic [N:0]   run_len,
    input  logic [N-1:0] lfsr_data,
    output logic         lfsr_load_seed,
    output logic [N-1:0] lfsr_seed_data,
    output logic         busy,
    output logic         done,
    output logic [N:0]   period,
    output logic [N-1:0] result_data,
    output logic         err_zero_seed,
    output logic         err_period
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    localparam logic [N:0] CNT_LIMIT  = {1'b1, {N{1'b0}}};
    localparam logic [N:0] MAX_PERIOD = {1'b0, {N{1'b1}}};

    state_t       state;
    state_t       state_nxt;
    logic [N-1:0] seed_q;
    logic         mode_q;
    logic [N:0]   run_len_q;
    logic [N:0]   cnt;
    logic         match_hit;
    logic         timeout_hit;
    logic         steps_hit;

    // A match wins over the timeout if both happen on the same step.
    assign match_hit   = (state == RUN) && !mode_q && (cnt != '0) && (lfsr_data == seed_q);
    assign timeout_hit = (state == RUN) && !mode_q && !match_hit && (cnt == CNT_LIMIT);
    assign steps_hit   = (state == RUN) && mode_q && (cnt == run_len_q);

    assign lfsr_seed_data = seed_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (seed_in == '0) ? DONE : LOAD;
                end
            end
            LOAD:    state_nxt = RUN;
            RUN: begin
                if (match_hit || timeout_hit || steps_hit) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy           = (state != IDLE);
        done           = (state == DONE);
        lfsr_load_seed = (state == LOAD);
    end

    // Job parameters are latched on an accepted start; results hold until the next one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seed_q        <= '0;
            mode_q        <= 1'b0;
            run_len_q     <= '0;
            cnt           <= '0;
            period        <= '0;
            result_data   <= '0;
            err_zero_seed <= 1'b0;
            err_period    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        seed_q        <= seed_in;
                        mode_q        <= mode;
                        run_len_q     <= run_len;
                        period        <= '0;
                        result_data   <= '0;
                        err_period    <= 1'b0;
                        err_zero_seed <= (seed_in == '0);
                    end
                end
                LOAD: begin
                    cnt <= '0;
                end
                RUN: begin
                    if (match_hit) begin
                        period      <= cnt;
                        result_data <= lfsr_data;
                        err_period  <= (cnt != MAX_PERIOD);
                    end else if (timeout_hit) begin
                        period     <= CNT_LIMIT;
                        err_period <= 1'b1;
                    end else if (steps_hit) begin
                        period      <= cnt;
                        result_data <= lfsr_data;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
